// File: rtl/tb04_pkg.sv
// Shared phase constants, state encoding and ROM address width for the fetch sequencer.
package tb04_pkg;

   localparam int unsigned ROM_ADDR_W = 12;
   localparam int unsigned PH_W       = 3;
   localparam int unsigned DATA_W     = 8;

   localparam logic [PH_W-1:0] PH_LATCH = 3'd0;
   localparam logic [PH_W-1:0] PH_JUMP  = 3'd3;
   localparam logic [PH_W-1:0] PH_FETCH = 3'd4;
   localparam logic [PH_W-1:0] PH_LAST  = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      HALT      = 3'd2,
      PEEK      = 3'd3,
      PEEK_WAIT = 3'd4
   } state_e;

   // Successor of a phase in the 0..PH_LAST ring.
   function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
      return (ph == PH_LAST) ? '0 : ph + PH_W'(1);
   endfunction

endpackage

// File: rtl/fetch_sequencer_phase_counter.sv
// Phase counter 0..PH_LAST with clear, force-to-last and step enable.
module phase_counter
   import tb04_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            set_last_i,
   input  logic            en_i,
   output logic [PH_W-1:0] cycle_o
);

   logic [PH_W-1:0] cycle_q, cycle_d;

   // Next phase: clear beats force beats step.
   always_comb begin
      cycle_d = cycle_q;
      if (clr_i) begin
         cycle_d = '0;
      end else if (set_last_i) begin
         cycle_d = PH_LAST;
      end else if (en_i) begin
         cycle_d = next_phase(cycle_q);
      end
   end

   // Phase register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   assign cycle_o = cycle_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns ROM phase/address, PC, jumps, stalls, halts and the fetched-byte latch.
// Optional ROM peek port enabled by defining DEBUG_PEEK_EN.
module fetch_sequencer
   import tb04_pkg::*;
#(
   parameter int unsigned ADDR_W    = ROM_ADDR_W,
   parameter int unsigned ROM_DEPTH = 2048,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              halt_req,
   input  logic              stall,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [PH_W-1:0]   cycle,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   output logic              instr_vld,
   output logic              halted,
   output logic              fault,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0]   jmp_addr_q, jmp_addr_d;
   logic                jmp_pend_q, jmp_pend_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                instr_vld_q, instr_vld_d;
   logic                halted_q, halted_d;
   logic                fault_q, fault_d;
   logic [PH_W-1:0]     cycle_w;
   logic                run_step;
   logic                fetch_oob;
   logic                ph_clr, ph_set_last;

   assign run_step  = (state_q == RUN) && !stall;
   assign fetch_oob = 32'(pc_q) >= ROM_DEPTH;

   // Phase ring advances only on unstalled RUN clocks; parked at 0 outside RUN, at PH_LAST for a peek.
   assign ph_clr      = (state_d != RUN) && (state_d != PEEK);
   assign ph_set_last = (state_d == PEEK);

   phase_counter u_phase (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (ph_clr),
      .set_last_i (ph_set_last),
      .en_i       (run_step),
      .cycle_o    (cycle_w)
   );

`ifdef DEBUG_PEEK_EN
   state_e              ret_q, ret_d;
   logic                dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
`else
   logic unused_dbg;
   assign unused_dbg = ^{dbg_req, dbg_addr};
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: fault/halt only at the end of phase 4; a peek request beats run.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (run) state_d = RUN;
`ifdef DEBUG_PEEK_EN
            if (dbg_req) state_d = PEEK;
`endif
         end
         RUN: begin
            if (run_step && (cycle_w == PH_LAST) && (fetch_oob || halt_req)) state_d = HALT;
         end
         HALT: begin
            if (run && !halt_req && !fault_q) state_d = RUN;
`ifdef DEBUG_PEEK_EN
            if (dbg_req) state_d = PEEK;
`endif
         end
`ifdef DEBUG_PEEK_EN
         PEEK:      state_d = PEEK_WAIT;
         PEEK_WAIT: state_d = ret_q;
`endif
         default:   state_d = IDLE;
      endcase
   end

   // Datapath/output next values: jump capture, PC update, fetch fault, byte latch.
   always_comb begin
      pc_d        = pc_q;
      jmp_pend_d  = jmp_pend_q;
      jmp_addr_d  = jmp_addr_q;
      instr_d     = instr_q;
      instr_vld_d = 1'b0;
      fault_d     = fault_q;
      if (state_q == RUN) begin
         // Jumps are captured even while stalled; the newest target wins.
         if (jump_valid) begin
            jmp_pend_d = 1'b1;
            jmp_addr_d = jump_addr;
         end
         if (run_step) begin
            if (cycle_w == PH_LATCH) begin
               instr_d     = rom_data;
               instr_vld_d = 1'b1;
            end
            if ((cycle_w == PH_JUMP) && (jump_valid || jmp_pend_q)) begin
               pc_d       = jump_valid ? jump_addr : jmp_addr_q;
               jmp_pend_d = 1'b0;
            end
            if (cycle_w == PH_FETCH) begin
               if (fetch_oob) begin
                  fault_d = 1'b1;
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end
         end
      end
      halted_d   = (state_d == IDLE) || (state_d == HALT);
      rom_addr_d = pc_d;
`ifdef DEBUG_PEEK_EN
      if (state_d == PEEK) rom_addr_d = dbg_addr;
      ret_d      = (state_d == PEEK) ? state_q : ret_q;
      dbg_ack_d  = (state_q == PEEK_WAIT);
      dbg_data_d = (state_q == PEEK_WAIT) ? rom_data : dbg_data_q;
`endif
   end

   // Datapath/output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= ADDR_W'(RESET_PC);
         rom_addr_q  <= ADDR_W'(RESET_PC);
         jmp_pend_q  <= 1'b0;
         jmp_addr_q  <= '0;
         instr_q     <= '0;
         instr_vld_q <= 1'b0;
         halted_q    <= 1'b1;
         fault_q     <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         rom_addr_q  <= rom_addr_d;
         jmp_pend_q  <= jmp_pend_d;
         jmp_addr_q  <= jmp_addr_d;
         instr_q     <= instr_d;
         instr_vld_q <= instr_vld_d;
         halted_q    <= halted_d;
         fault_q     <= fault_d;
      end
   end

`ifdef DEBUG_PEEK_EN
   // Peek bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ret_q      <= IDLE;
         dbg_ack_q  <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         ret_q      <= ret_d;
         dbg_ack_q  <= dbg_ack_d;
         dbg_data_q <= dbg_data_d;
      end
   end

   assign dbg_ack  = dbg_ack_q;
   assign dbg_data = dbg_data_q;
`else
   assign dbg_ack  = 1'b0;
   assign dbg_data = '0;
`endif

   assign cycle     = cycle_w;
   assign rom_addr  = rom_addr_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign instr_vld = instr_vld_q;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-clock vector table plus fault, peek and reset sequences.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, run, halt_req, stall, jump_valid, dbg_req;
   logic [11:0] jump_addr, dbg_addr;
   logic [7:0]  rom_data;
   logic [2:0]  cycle;
   logic [11:0] rom_addr, pc;
   logic [7:0]  instr, dbg_data;
   logic        instr_vld, halted, fault, dbg_ack;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(12), .ROM_DEPTH(2048), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .stall(stall),
      .jump_valid(jump_valid), .jump_addr(jump_addr), .rom_data(rom_data),
      .cycle(cycle), .rom_addr(rom_addr), .pc(pc), .instr(instr),
      .instr_vld(instr_vld), .halted(halted), .fault(fault),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
   );

   // Synchronous ROM model: samples its address when cycle is 4, otherwise holds its output.
   logic [7:0] rom [0:2047];
   always @(posedge clk) begin
      if (rst) rom_data <= 8'h00;
      else if (cycle == 3'd4) rom_data <= rom_addr[11] ? 8'hFF : rom[rom_addr[10:0]];
   end

   typedef struct {
      logic       run, hlt_req, stl, jv;
      logic [11:0] ja;
      logic [2:0] cyc;
      logic [11:0] pc;
      logic       vld;
      logic [7:0] ins;
      logic       hlt;
   } vec_t;

   localparam int NV = 58;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, input logic h, input logic s, input logic j,
                               input logic [11:0] a, input logic [2:0] c, input logic [11:0] p,
                               input logic v, input logic [7:0] i, input logic hl);
      vec_t t;
      t.run = r; t.hlt_req = h; t.stl = s; t.jv = j; t.ja = a;
      t.cyc = c; t.pc = p; t.vld = v; t.ins = i; t.hlt = hl;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h want=%h", name, got, want);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = 8'(i * 13 + 7);
      rom[11'h000] = 8'hA1; rom[11'h001] = 8'hB2; rom[11'h002] = 8'hC3;
      rom[11'h003] = 8'hD4; rom[11'h004] = 8'h4E; rom[11'h010] = 8'hE7;
      rom[11'h100] = 8'h5A; rom[11'h101] = 8'h6B; rom[11'h7FF] = 8'h9C;

      //          run hr st jv addr     cyc pc      vld instr  halted
      vecs[0]  = mk(1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 8'h00, 0);
      vecs[1]  = mk(1, 0, 0, 0, 12'h000, 1, 12'h000, 1, 8'h00, 0);
      vecs[2]  = mk(1, 0, 0, 0, 12'h000, 2, 12'h000, 0, 8'h00, 0);
      vecs[3]  = mk(1, 0, 0, 0, 12'h000, 3, 12'h000, 0, 8'h00, 0);
      vecs[4]  = mk(1, 0, 0, 0, 12'h000, 4, 12'h000, 0, 8'h00, 0);
      vecs[5]  = mk(1, 0, 0, 0, 12'h000, 0, 12'h001, 0, 8'h00, 0);
      vecs[6]  = mk(1, 0, 0, 0, 12'h000, 1, 12'h001, 1, 8'hA1, 0);
      vecs[7]  = mk(1, 0, 0, 0, 12'h000, 2, 12'h001, 0, 8'hA1, 0);
      vecs[8]  = mk(1, 0, 0, 0, 12'h000, 3, 12'h001, 0, 8'hA1, 0);
      vecs[9]  = mk(1, 0, 0, 0, 12'h000, 4, 12'h001, 0, 8'hA1, 0);
      vecs[10] = mk(1, 0, 0, 0, 12'h000, 0, 12'h002, 0, 8'hA1, 0);
      vecs[11] = mk(1, 0, 0, 0, 12'h000, 1, 12'h002, 1, 8'hB2, 0);
      vecs[12] = mk(1, 0, 0, 0, 12'h000, 2, 12'h002, 0, 8'hB2, 0);
      vecs[13] = mk(1, 0, 0, 0, 12'h000, 3, 12'h002, 0, 8'hB2, 0);
      vecs[14] = mk(1, 0, 0, 0, 12'h000, 4, 12'h002, 0, 8'hB2, 0);
      vecs[15] = mk(1, 0, 0, 0, 12'h000, 0, 12'h003, 0, 8'hB2, 0);
      vecs[16] = mk(1, 0, 0, 0, 12'h000, 1, 12'h003, 1, 8'hC3, 0);
      // jump in phase 1
      vecs[17] = mk(1, 0, 0, 1, 12'h100, 2, 12'h003, 0, 8'hC3, 0);
      vecs[18] = mk(1, 0, 0, 0, 12'h000, 3, 12'h003, 0, 8'hC3, 0);
      vecs[19] = mk(1, 0, 0, 0, 12'h000, 4, 12'h100, 0, 8'hC3, 0);
      vecs[20] = mk(1, 0, 0, 0, 12'h000, 0, 12'h101, 0, 8'hC3, 0);
      vecs[21] = mk(1, 0, 0, 0, 12'h000, 1, 12'h101, 1, 8'h5A, 0);
      vecs[22] = mk(1, 0, 0, 0, 12'h000, 2, 12'h101, 0, 8'h5A, 0);
      // 3-clock stall in phase 2 with a jump pulsed inside it
      vecs[23] = mk(1, 0, 1, 0, 12'h000, 2, 12'h101, 0, 8'h5A, 0);
      vecs[24] = mk(1, 0, 1, 1, 12'h004, 2, 12'h101, 0, 8'h5A, 0);
      vecs[25] = mk(1, 0, 1, 0, 12'h000, 2, 12'h101, 0, 8'h5A, 0);
      vecs[26] = mk(1, 0, 0, 0, 12'h000, 3, 12'h101, 0, 8'h5A, 0);
      vecs[27] = mk(1, 0, 0, 0, 12'h000, 4, 12'h004, 0, 8'h5A, 0);
      vecs[28] = mk(1, 0, 0, 0, 12'h000, 0, 12'h005, 0, 8'h5A, 0);
      vecs[29] = mk(1, 0, 0, 0, 12'h000, 1, 12'h005, 1, 8'h4E, 0);
      // pended jump overridden by a phase-3 jump; phase-4 jump deferred to next phase 3
      vecs[30] = mk(1, 0, 0, 1, 12'h102, 2, 12'h005, 0, 8'h4E, 0);
      vecs[31] = mk(1, 0, 0, 0, 12'h000, 3, 12'h005, 0, 8'h4E, 0);
      vecs[32] = mk(1, 0, 0, 1, 12'h101, 4, 12'h101, 0, 8'h4E, 0);
      vecs[33] = mk(1, 0, 0, 1, 12'h002, 0, 12'h102, 0, 8'h4E, 0);
      vecs[34] = mk(1, 0, 0, 0, 12'h000, 1, 12'h102, 1, 8'h6B, 0);
      vecs[35] = mk(1, 0, 0, 0, 12'h000, 2, 12'h102, 0, 8'h6B, 0);
      vecs[36] = mk(1, 0, 0, 0, 12'h000, 3, 12'h102, 0, 8'h6B, 0);
      vecs[37] = mk(1, 0, 0, 0, 12'h000, 4, 12'h002, 0, 8'h6B, 0);
      vecs[38] = mk(1, 0, 0, 0, 12'h000, 0, 12'h003, 0, 8'h6B, 0);
      vecs[39] = mk(1, 0, 0, 0, 12'h000, 1, 12'h003, 1, 8'hC3, 0);
      // halt request from phase 1, then resume
      vecs[40] = mk(1, 1, 0, 0, 12'h000, 2, 12'h003, 0, 8'hC3, 0);
      vecs[41] = mk(1, 1, 0, 0, 12'h000, 3, 12'h003, 0, 8'hC3, 0);
      vecs[42] = mk(1, 1, 0, 0, 12'h000, 4, 12'h003, 0, 8'hC3, 0);
      vecs[43] = mk(1, 1, 0, 0, 12'h000, 0, 12'h004, 0, 8'hC3, 1);
      vecs[44] = mk(1, 1, 0, 0, 12'h000, 0, 12'h004, 0, 8'hC3, 1);
      vecs[45] = mk(1, 0, 0, 0, 12'h000, 0, 12'h004, 0, 8'hC3, 0);
      vecs[46] = mk(1, 0, 0, 0, 12'h000, 1, 12'h004, 1, 8'hD4, 0);
      vecs[47] = mk(1, 0, 0, 0, 12'h000, 2, 12'h004, 0, 8'hD4, 0);
      vecs[48] = mk(1, 0, 0, 0, 12'h000, 3, 12'h004, 0, 8'hD4, 0);
      vecs[49] = mk(1, 0, 0, 0, 12'h000, 4, 12'h004, 0, 8'hD4, 0);
      vecs[50] = mk(1, 0, 0, 0, 12'h000, 0, 12'h005, 0, 8'hD4, 0);
      vecs[51] = mk(1, 0, 0, 0, 12'h000, 1, 12'h005, 1, 8'h4E, 0);
      vecs[52] = mk(1, 0, 0, 0, 12'h000, 2, 12'h005, 0, 8'h4E, 0);
      vecs[53] = mk(1, 0, 0, 0, 12'h000, 3, 12'h005, 0, 8'h4E, 0);
      vecs[54] = mk(1, 0, 0, 0, 12'h000, 4, 12'h005, 0, 8'h4E, 0);
      // halt_req with stall in phase 4: stall wins, halt taken once phase 4 completes
      vecs[55] = mk(1, 1, 1, 0, 12'h000, 4, 12'h005, 0, 8'h4E, 0);
      vecs[56] = mk(1, 1, 0, 0, 12'h000, 0, 12'h006, 0, 8'h4E, 1);
      vecs[57] = mk(0, 0, 0, 0, 12'h000, 0, 12'h006, 0, 8'h4E, 1);

      rst = 1'b1; run = 1'b0; halt_req = 1'b0; stall = 1'b0; jump_valid = 1'b0;
      jump_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
      step();
      step();
      check("rst_cycle",    64'(cycle),     64'(0));
      check("rst_pc",       64'(pc),        64'(0));
      check("rst_instr",    64'(instr),     64'(0));
      check("rst_vld",      64'(instr_vld), 64'(0));
      check("rst_halted",   64'(halted),    64'(1));
      check("rst_fault",    64'(fault),     64'(0));
      check("rst_dbg",      64'({dbg_ack, dbg_data}), 64'(0));

      rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         run = vecs[i].run; halt_req = vecs[i].hlt_req; stall = vecs[i].stl;
         jump_valid = vecs[i].jv; jump_addr = vecs[i].ja;
         step();
         check($sformatf("vec%0d{cyc,pc,vld,instr,halted,fault}", i),
               64'({cycle, pc, instr_vld, instr, halted, fault}),
               64'({vecs[i].cyc, vecs[i].pc, vecs[i].vld, vecs[i].ins, vecs[i].hlt, 1'b0}));
      end
      run = 1'b0; halt_req = 1'b0; stall = 1'b0; jump_valid = 1'b0;

      // Out-of-range fetch: jump to last ROM word, fetch it, then fault on 0x800.
      run = 1'b1;
      step();
      check("resume_run", 64'({cycle, halted}), 64'({3'd0, 1'b0}));
      step();
      check("resume_instr", 64'({instr_vld, instr}), 64'({1'b1, rom[11'h005]}));
      jump_valid = 1'b1; jump_addr = 12'h7FF;
      step();
      jump_valid = 1'b0;
      step();
      step();
      check("jump_7ff_pc", 64'({cycle, pc, rom_addr}), 64'({3'd4, 12'h7FF, 12'h7FF}));
      step();
      check("inc_800_pc", 64'({cycle, pc, fault}), 64'({3'd0, 12'h800, 1'b0}));
      step();
      check("instr_7ff", 64'({instr_vld, instr}), 64'({1'b1, 8'h9C}));
      step(); step(); step();
      check("pre_fault", 64'({cycle, fault, halted}), 64'({3'd4, 1'b0, 1'b0}));
      step();
      check("fault_set", 64'({cycle, pc, fault, halted}), 64'({3'd0, 12'h800, 1'b1, 1'b1}));
      step();
      check("fault_no_vld", 64'({instr_vld, instr, fault, halted}), 64'({1'b0, 8'h9C, 1'b1, 1'b1}));
      step(); step();
      check("fault_sticky", 64'({cycle, fault, halted, pc}), 64'({3'd0, 1'b1, 1'b1, 12'h800}));

`ifdef DEBUG_PEEK_EN
      dbg_req = 1'b1; dbg_addr = 12'h010;
      step();
      check("peek_drive", 64'({cycle, rom_addr, dbg_ack}), 64'({3'd4, 12'h010, 1'b0}));
      dbg_req = 1'b0;
      step();
      check("peek_wait", 64'({cycle, dbg_ack}), 64'({3'd0, 1'b0}));
      step();
      check("peek_ack", 64'({dbg_ack, dbg_data}), 64'({1'b1, 8'hE7}));
      check("peek_untouched", 64'({pc, instr, halted, fault}), 64'({12'h800, 8'h9C, 1'b1, 1'b1}));
      step();
      check("peek_done", 64'({dbg_ack, dbg_data, cycle}), 64'({1'b0, 8'hE7, 3'd0}));
`else
      dbg_req = 1'b1; dbg_addr = 12'h010;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("nopeek%0d{cyc,ack,data,halted}", k),
               64'({cycle, dbg_ack, dbg_data, halted}), 64'({3'd0, 1'b0, 8'h00, 1'b1}));
      end
      dbg_req = 1'b0;
`endif

      // Only reset clears the fault.
      run = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("fault_clear", 64'({fault, pc, halted, instr, cycle}), 64'({1'b0, 12'h000, 1'b1, 8'h00, 3'd0}));

      // Reset in the middle of a phase sequence aborts it.
      run = 1'b1;
      step(); step(); step();
      check("mid_run", 64'({cycle, halted}), 64'({3'd2, 1'b0}));
      rst = 1'b1;
      step();
      check("mid_rst", 64'({cycle, pc, halted, instr_vld, instr}), 64'({3'd0, 12'h000, 1'b1, 1'b0, 8'h00}));
      rst = 1'b0; run = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
